// File: rtl/cyp_ep6_tx.sv
// cyp_ep6_tx: EP6 IN write path for the FX2 slave FIFO, cyp_clk domain.
// Pops 16-bit words from the read-back async FIFO (non-FWFT, data one cycle
// after fifo_ren) and strobes each into the FX2 with usb_slwr.
// Optional feature macro: CYP_TX_PKTEND_EN enables the idle timeout and the
// PKTEND state that commits short packets. Without it, usb_pktend is tied
// high and only full packets are counted.
//
// Handshake: a word is committed to the FX2 in a WRITE cycle only when
// usb_flagc=1 (not full); while usb_flagc=0 the word stays on usb_fd_o with
// usb_slwr high. fifo_ren is a single-cycle pop, issued only after
// fifo_rempty was seen low.
module cyp_ep6_tx #(
  parameter int unsigned PKT_WORDS    = 256,
  parameter int unsigned IDLE_TIMEOUT = 1024
) (
  input  logic        cyp_clk,
  input  logic        rst_n,
  input  logic        tx_en,
  input  logic [15:0] fifo_rdata,
  input  logic        fifo_rempty,
  output logic        fifo_ren,
  input  logic        usb_flagc,
  output logic [1:0]  usb_fifoaddr,
  output logic        usb_slwr,
  output logic        usb_pktend,
  output logic [15:0] usb_fd_o,
  output logic        usb_fd_oe,
  output logic        tx_busy,
  output logic [15:0] pkt_cnt
);

  if (PKT_WORDS < 2 || PKT_WORDS > 65535 || IDLE_TIMEOUT < 1 || IDLE_TIMEOUT > 65535) begin : g_bad_param
    $error("cyp_ep6_tx: PKT_WORDS or IDLE_TIMEOUT out of range");
  end

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    LOAD   = 3'd2,
    WRITE  = 3'd3,
    PKTEND = 3'd4
  } state_t;

  localparam logic [15:0] LAST_WORD = 16'(PKT_WORDS - 1);

  state_t      state;
  logic [15:0] data_q;
  logic [15:0] word_cnt;
  logic        go;
  logic        expire;

  // A new word may be started when granted, data is waiting and EP6 has room.
  assign go = tx_en & ~fifo_rempty & usb_flagc;

`ifdef CYP_TX_PKTEND_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(IDLE_TIMEOUT - 1);
  logic [15:0] idle_cnt;

  // Expiry only counts with a partial packet pending and the bus granted.
  assign expire = (idle_cnt == TIMEOUT_LAST) & (word_cnt != 16'd0) & tx_en;

  // Idle timer: runs in IDLE with a partial packet, holds while tx_en=0,
  // clears on leaving IDLE (go or expiry) and whenever no words are pending.
  always_ff @(posedge cyp_clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= 16'd0;
    end else if (state != IDLE || word_cnt == 16'd0 || go || expire) begin
      idle_cnt <= 16'd0;
    end else if (tx_en) begin
      idle_cnt <= idle_cnt + 16'd1;
    end
  end
`else
  assign expire = 1'b0;
`endif

  // Main FSM: sequencing, data capture and word/packet accounting.
  always_ff @(posedge cyp_clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      data_q   <= 16'd0;
      word_cnt <= 16'd0;
      pkt_cnt  <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (go)          state <= FETCH;
          else if (expire) state <= PKTEND;
        end
        FETCH: state <= LOAD;
        LOAD: begin
          data_q <= fifo_rdata;
          state  <= WRITE;
        end
        WRITE: begin
          if (usb_flagc) begin
            // The FX2 auto-commits a full packet; only the counters move.
            if (word_cnt == LAST_WORD) begin
              word_cnt <= 16'd0;
              pkt_cnt  <= pkt_cnt + 16'd1;
            end else begin
              word_cnt <= word_cnt + 16'd1;
            end
            state <= go ? FETCH : IDLE;
          end
        end
        PKTEND: begin
`ifdef CYP_TX_PKTEND_EN
          if (usb_flagc) begin
            word_cnt <= 16'd0;
            pkt_cnt  <= pkt_cnt + 16'd1;
            state    <= IDLE;
          end
`else
          state <= IDLE;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Bus strobes decoded from the state register and the EP6 full flag.
  always_comb begin
    fifo_ren  = (state == FETCH);
    usb_slwr  = ~((state == WRITE) & usb_flagc);
    usb_fd_oe = (state == WRITE);
    tx_busy   = (state != IDLE);
`ifdef CYP_TX_PKTEND_EN
    usb_pktend = ~((state == PKTEND) & usb_flagc);
`else
    usb_pktend = 1'b1;
`endif
  end

  assign usb_fd_o     = data_q;
  assign usb_fifoaddr = 2'b10;

endmodule

// File: tb/tb_cyp_ep6_tx.sv
// tb_cyp_ep6_tx: directed bench for cyp_ep6_tx with a FIFO model, an
// expected-word queue and a monitor that checks every usb_slwr strobe.
module tb_cyp_ep6_tx;

`ifdef CYP_TX_PKTEND_EN
  localparam int PE = 1;
`else
  localparam int PE = 0;
`endif

  logic        cyp_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tx_en = 1'b0;
  logic [15:0] fifo_rdata = 16'd0;
  logic        fifo_rempty;
  logic        fifo_ren;
  logic        usb_flagc = 1'b1;
  logic [1:0]  usb_fifoaddr;
  logic        usb_slwr;
  logic        usb_pktend;
  logic [15:0] usb_fd_o;
  logic        usb_fd_oe;
  logic        tx_busy;
  logic [15:0] pkt_cnt;

  cyp_ep6_tx #(.PKT_WORDS(256), .IDLE_TIMEOUT(16)) dut (
    .cyp_clk(cyp_clk), .rst_n(rst_n), .tx_en(tx_en),
    .fifo_rdata(fifo_rdata), .fifo_rempty(fifo_rempty), .fifo_ren(fifo_ren),
    .usb_flagc(usb_flagc), .usb_fifoaddr(usb_fifoaddr), .usb_slwr(usb_slwr),
    .usb_pktend(usb_pktend), .usb_fd_o(usb_fd_o), .usb_fd_oe(usb_fd_oe),
    .tx_busy(tx_busy), .pkt_cnt(pkt_cnt)
  );

  // ---------------- clock / reset ----------------
  always #5 cyp_clk = ~cyp_clk;
  int cyc = 0;
  always @(posedge cyp_clk) cyc <= cyc + 1;

  // ---------------- FIFO model ----------------
  logic [15:0] fifo_mem [0:2047];
  int push_cnt = 0;
  int pop_cnt = 0;
  assign fifo_rempty = (push_cnt == pop_cnt);
  always @(posedge cyp_clk) begin
    if (fifo_ren) begin
      fifo_rdata <= fifo_mem[pop_cnt];
      pop_cnt    <= pop_cnt + 1;
    end
  end

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q[$];
  int compared = 0;
  int mismatched = 0;
  int slwr_count = 0;
  int pktend_count = 0;
  int ren_count = 0;
  int last_slwr_cyc = 0;
  int pktend_cyc = 0;
  bit check_spacing = 1'b0;
  bit sp_started = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: consumes one expected word per write strobe.
  always @(negedge cyp_clk) begin
    if (rst_n) begin
      if (fifo_ren) begin
        ren_count++;
        check("no_underflow", 32'(fifo_rempty), 32'd0);
      end
      if (!usb_slwr) begin
        slwr_count++;
        if (check_spacing) begin
          if (sp_started) check("slwr_spacing", 32'(cyc - last_slwr_cyc), 32'd3);
          sp_started = 1'b1;
        end
        last_slwr_cyc = cyc;
        check("fd_oe_on_write", 32'(usb_fd_oe), 32'd1);
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL write_data: got 0x%0h, expected no write (cycle %0d)", usb_fd_o, cyc);
        end else begin
          check("write_data", 32'(usb_fd_o), 32'(exp_q.pop_front()));
        end
      end
      if (!usb_pktend) begin
        pktend_count++;
        pktend_cyc = cyc;
        check("pktend_slwr_high", 32'(usb_slwr), 32'd1);
        check("pktend_oe_low", 32'(usb_fd_oe), 32'd0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge cyp_clk);
    #1;
  endtask

  task automatic push_word(input logic [15:0] w);
    fifo_mem[push_cnt] = w;
    push_cnt++;
    exp_q.push_back(w);
  endtask

  task automatic wait_slwr(input string name, input int target, input int budget);
    int n = 0;
    while (slwr_count < target && n < budget) begin
      tick();
      n++;
    end
    check(name, 32'(slwr_count), 32'(target));
  endtask

  task automatic wait_fetch(input string name);
    int n = 0;
    while (fifo_ren !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check(name, 32'(fifo_ren), 32'd1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ren"},    32'(fifo_ren),     32'd0);
    check({tag, "_slwr"},   32'(usb_slwr),     32'd1);
    check({tag, "_pktend"}, 32'(usb_pktend),   32'd1);
    check({tag, "_oe"},     32'(usb_fd_oe),    32'd0);
    check({tag, "_fd"},     32'(usb_fd_o),     32'd0);
    check({tag, "_busy"},   32'(tx_busy),      32'd0);
    check({tag, "_pkt"},    32'(pkt_cnt),      32'd0);
    check({tag, "_addr"},   32'(usb_fifoaddr), 32'd2);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int exp_pkt;
    int exp_pe;
    int w;
    int base;
    int ren_snap;
    int n;

    exp_pkt = 0;
    exp_pe = 0;
    #2;
    check_reset_outputs("reset");
    idle(3);
    rst_n = 1'b1;
    tick();

    // T1: two full packets, back-to-back at one word per three cycles.
    for (int i = 0; i < 512; i++) push_word(16'(i));
    sp_started = 1'b0;
    check_spacing = 1'b1;
    tx_en = 1'b1;
    wait_slwr("t1_writes", 512, 3 * 512 + 50);
    check_spacing = 1'b0;
    idle(5);
    exp_pkt = 2;
    check("t1_pkt_cnt", 32'(pkt_cnt), 32'(exp_pkt));
    check("t1_word_cnt", 32'(dut.word_cnt), 32'd0);
    check("t1_pktend", 32'(pktend_count), 32'(exp_pe));
    check("t1_queue_empty", 32'(exp_q.size()), 32'd0);

    // T2: short packet, committed by the idle timeout when enabled.
    base = slwr_count;
    for (int i = 0; i < 5; i++) push_word(16'h0A00 + 16'(i));
    wait_slwr("t2_writes", base + 5, 40);
    w = last_slwr_cyc;
    idle(40);
    exp_pkt += PE;
    exp_pe += PE;
    check("t2_pktend", 32'(pktend_count), 32'(exp_pe));
    check("t2_pkt_cnt", 32'(pkt_cnt), 32'(exp_pkt));
`ifdef CYP_TX_PKTEND_EN
    check("t2_pktend_delay", 32'(pktend_cyc - w), 32'd17);
`endif

    // T3: EP6 full during WRITE of 0x1234 for 10 cycles.
    base = slwr_count;
    push_word(16'h1234);
    wait_fetch("t3_fetch");
    tick();
    usb_flagc = 1'b0;
    tick();
    for (int i = 0; i < 10; i++) begin
      check("t3_stall_slwr", 32'(usb_slwr), 32'd1);
      check("t3_stall_data", 32'(usb_fd_o), 32'h1234);
      check("t3_stall_oe", 32'(usb_fd_oe), 32'd1);
      tick();
    end
    usb_flagc = 1'b1;
    wait_slwr("t3_writes", base + 1, 10);
    idle(40);
    check("t3_single_write", 32'(slwr_count), 32'(base + 1));
    exp_pkt += PE;
    exp_pe += PE;
    check("t3_pktend", 32'(pktend_count), 32'(exp_pe));

    // T4: grant withdrawn during FETCH; that word still completes.
    base = slwr_count;
    push_word(16'hBEEF);
    push_word(16'hCAFE);
    wait_fetch("t4_fetch");
    tx_en = 1'b0;
    wait_slwr("t4_first_write", base + 1, 10);
    ren_snap = ren_count;
    idle(30);
    check("t4_busy", 32'(tx_busy), 32'd0);
    check("t4_no_ren", 32'(ren_count), 32'(ren_snap));
    check("t4_no_pktend", 32'(pktend_count), 32'(exp_pe));
    check("t4_pending", 32'(exp_q.size()), 32'd1);
    tx_en = 1'b1;
    wait_slwr("t4_second_write", base + 2, 20);
    idle(40);
    exp_pkt += PE;
    exp_pe += PE;
    check("t4_pktend", 32'(pktend_count), 32'(exp_pe));
    check("t4_pkt_cnt", 32'(pkt_cnt), 32'(exp_pkt));

    // T5: reset during LOAD drops the in-flight word.
    push_word(16'hAAAA);
    wait_fetch("t5_fetch");
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t5_reset");
    void'(exp_q.pop_back());
    exp_pkt = 0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    base = slwr_count;
    push_word(16'h5A5A);
    wait_slwr("t5_write_after_reset", base + 1, 20);
    w = last_slwr_cyc;

    // T6: data arrives in the very cycle the timeout expires; FETCH wins.
    n = 0;
    while (cyc < w + 16 && n < 40) begin
      tick();
      n++;
    end
    check("t6_align", 32'(cyc), 32'(w + 16));
    push_word(16'h6006);
    wait_slwr("t6_write", base + 2, 20);
    check("t6_write_cycle", 32'(last_slwr_cyc), 32'(w + 19));
    check("t6_no_pktend", 32'(pktend_count), 32'(exp_pe));
    idle(40);
    exp_pkt += PE;
    exp_pe += PE;
    check("t6_pktend", 32'(pktend_count), 32'(exp_pe));
    check("t6_pkt_cnt", 32'(pkt_cnt), 32'(exp_pkt));
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/cyp_ep6_tx.md
# cyp_ep6_tx

Host-bound write path for the CY68013 (FX2) slave FIFO interface, clocked by the 48 MHz cyp_clk (FX2 IFCLK). It pops 16-bit words from the SDRAM read-back async FIFO (read port in the cyp_clk domain, standard non-FWFT read, data valid one cycle after fifo_ren) and writes them into EP6 IN with usb_slwr. It counts words per USB packet and, optionally, commits short packets with usb_pktend after an idle timeout. It is the transmit counterpart of the EP2 OUT receive path and shares the FX2 bus with it through tx_en.

## Interface
- PKT_WORDS, 256, EP6 packet size in 16-bit words (512 bytes); range 2..65535.
- IDLE_TIMEOUT, 1024, idle cycles before a partial packet is committed; range 1..65535.
- cyp_clk  input  1  48 MHz FX2 interface clock; all logic is on its rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- tx_en  input  1  bus grant from the FX2 bus arbiter; 1 = this block may drive the bus.
- fifo_rdata  input  16  async FIFO read data, valid the cycle after fifo_ren.
- fifo_rempty  input  1  async FIFO empty.
- fifo_ren  output  1  async FIFO read enable, one cycle per word.
- usb_flagc  input  1  EP6 FIFO status; 1 = not full, 0 = full.
- usb_fifoaddr  output  2  constant 2'b10 (EP6).
- usb_slwr  output  1  FX2 write strobe, active-low.
- usb_pktend  output  1  FX2 packet end, active-low.
- usb_fd_o  output  16  data to FX2.
- usb_fd_oe  output  1  1 = drive usb_fd_o onto the bus.
- tx_busy  output  1  1 whenever state != IDLE.
- pkt_cnt  output  16  packets committed, wraps at 16'hFFFF -> 0.

## Operation
- The FSM has 5 states: IDLE, FETCH, LOAD, WRITE, PKTEND. Reset state is IDLE.
- IDLE
  - Goes to FETCH when tx_en & !fifo_rempty & usb_flagc.
  - Otherwise goes to PKTEND on timeout expiry. Requires CYP_TX_PKTEND_EN.
  - Otherwise stays in IDLE.
- FETCH: fifo_ren=1 for this cycle only; goes to LOAD.
- LOAD: fifo_rdata is captured into data_q at the end of the cycle; goes to WRITE.
- WRITE
  - usb_fd_o=data_q and usb_fd_oe=1 throughout.
  - If usb_flagc=1: usb_slwr=0 this cycle, the word is committed, word_cnt increments. The FSM then goes to FETCH if tx_en & !fifo_rempty & usb_flagc, else to IDLE.
  - If usb_flagc=0: usb_slwr=1 and the FSM stays in WRITE, holding data_q.
- word_cnt is 16 bits. When the committed word is number PKT_WORDS (word_cnt==PKT_WORDS-1), word_cnt goes to 0 and pkt_cnt increments. The FX2 auto-commits a full packet, so no pktend is issued.
- PKTEND
  - If usb_flagc=1: usb_pktend=0 for one cycle (usb_slwr=1, usb_fd_oe=0), then word_cnt=0, pkt_cnt increments, and the FSM goes to IDLE.
  - Otherwise it waits in PKTEND.
- Timeout counter
  - Increments each IDLE cycle while word_cnt!=0 & tx_en.
  - Clears on leaving IDLE and whenever word_cnt==0.
  - Holds while tx_en=0.
  - Expiry is counter==IDLE_TIMEOUT-1.
- Boundary conditions
  - No zero-length packets: there is no pktend when word_cnt==0.
  - If the timeout expires in the same cycle that new data and flagc are available, FETCH wins and the counter clears.
  - tx_en falling mid-word: FETCH/LOAD/WRITE run to completion (the word is not lost), then the FSM goes to IDLE. PKTEND is not entered while tx_en=0.
  - fifo_ren is only issued when fifo_rempty=0; a FIFO underflow is impossible.
  - Reset mid-operation returns every register to its reset value. A word held in data_q and not yet written is dropped.

## Timing
- Reset values: fifo_ren=0, usb_slwr=1, usb_pktend=1, usb_fd_oe=0, usb_fd_o=0, tx_busy=0, pkt_cnt=0, word_cnt=0, timeout counter=0. usb_fifoaddr=2'b10 at all times.
- fifo_ren, usb_slwr, usb_pktend, usb_fd_oe and tx_busy are decoded from the state register and usb_flagc. usb_fd_o is the data_q register.
- Latency from the IDLE cycle that sees the go condition: fifo_ren at +1, data captured at +2, usb_slwr low at +3.
- Throughput is 1 word per 3 cycles (16 Mword/s) with no full stall.
- data_q is stable for the whole of WRITE. usb_fd_oe rises no later than the cycle usb_slwr falls.
- usb_pktend and usb_slwr are never low in the same cycle.

## Configuration
- CYP_TX_PKTEND_EN defined: the timeout counter and the PKTEND state are implemented as described.
- CYP_TX_PKTEND_EN undefined:
  - usb_pktend is tied to 1 and the timeout counter and PKTEND state are absent.
  - Partial packets stay in the FX2 until later data fills them.
  - pkt_cnt counts full packets only.

## Test plan
- Preload 512 words 0x0000..0x01FF, usb_flagc=1, tx_en=1:
  - 512 usb_slwr pulses with usb_fd_o matching in order; pkt_cnt=2 and word_cnt=0.
  - usb_pktend never low; 3-cycle spacing between strobes.
- Preload 5 words, IDLE_TIMEOUT=16, macro defined:
  - 5 writes, then exactly 1 usb_pktend pulse 16 IDLE cycles later; pkt_cnt=1.
  - With the macro undefined: no pktend and pkt_cnt=0.
- Drop usb_flagc to 0 during WRITE of word 0x1234 for 10 cycles:
  - usb_slwr held high and usb_fd_o=0x1234 held.
  - On flagc=1 a single write occurs; no duplicated or lost word.
- Deassert tx_en in the FETCH cycle:
  - That word is still written, then IDLE with tx_busy=0.
  - No further fifo_ren until tx_en=1; no pktend while tx_en=0.
- Assert rst_n=0 during LOAD:
  - All outputs at reset values within the same cycle; pkt_cnt=0.
  - After release, the next FIFO word is written normally.
- Timeout expiry coinciding with fifo_rempty falling: FETCH taken, no pktend; the packet continues accumulating.
